// File: rtl/memio_if.sv
// memio_if: cpu-side RAM port bundle for the memio stage.
//   RAMaddr  word address from the cpu MAR
//   RAMin    write data from the cpu MDR
//   we       write strobe, sampled on posedge clk
//   RAMout   combinational read data back to the cpu
// master modport is the cpu side, slave modport is memio.
interface memio_if;
  logic [15:0] RAMaddr;
  logic [15:0] RAMin;
  logic        we;
  logic [15:0] RAMout;

  modport master (output RAMaddr, output RAMin, output we, input RAMout);
  modport slave  (input RAMaddr, input RAMin, input we, output RAMout);
endinterface

// File: rtl/memio.sv
// memio: memory/IO stage behind the cpu RAM port.
// Word-addressed main RAM plus a memory-mapped UART transmitter fed by a
// byte FIFO, so cpu stores never stall. Read data is combinational.
//
// Ports:
//   clk    system clock, all state changes on posedge
//   reset  asynchronous, active-low
//   bus    memio_if.slave (RAMaddr, RAMin, we -> RAMout)
//   tx     UART serial out, idle high
//   rx     UART serial in (only with MEMIO_RX_EN)
//
// Address map:
//   0x0000..RAM_WORDS-1  RAM
//   0xFF00 TXDATA  write pushes RAMin[7:0]; reads 0
//   0xFF01 STATUS  {8'h00, ovf, rxv, busy, full, count[3:0]}; write clears ovf
//   0xFF02 RXDATA  {8'h00, byte}; write clears rxv (MEMIO_RX_EN only)
//
// Build option: define MEMIO_RX_EN to add the rx port and receiver.
//
// TX FSM
//   state   | meaning
//   S_IDLE  | tx high, pops the FIFO head when count != 0
//   S_START | start bit (tx low) for CLK_DIV cycles
//   S_DATA  | 8 data bits, LSB first, CLK_DIV cycles each
//   S_STOP  | stop bit (tx high) for CLK_DIV cycles
//
// RX FSM (MEMIO_RX_EN)
//   state   | meaning
//   R_IDLE  | waiting for a falling edge on synchronised rx
//   R_START | half-bit wait, start must still be low
//   R_DATA  | sampling 8 data bits at bit centres
//   R_STOP  | sampling stop bit, high commits the byte
module memio #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 434
) (
  input  logic   clk,
  input  logic   reset,
  memio_if.slave bus,
  output logic   tx
`ifdef MEMIO_RX_EN
  ,
  input  logic   rx
`endif
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_DIV + 1);

  localparam logic [15:0]   RAM_LIMIT  = 16'(RAM_WORDS);
  localparam logic [15:0]   A_TXDATA   = 16'hFF00;
  localparam logic [15:0]   A_STATUS   = 16'hFF01;
  localparam logic [3:0]    FIFO_FULL  = 4'(FIFO_DEPTH);
  localparam logic [TW-1:0] BIT_RELOAD = TW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

  // ---------------- RAM (contents intentionally not reset) ----------------
  logic [15:0] ram_mem [RAM_WORDS];
  logic        ram_sel;

  assign ram_sel = (bus.RAMaddr < RAM_LIMIT);

  always_ff @(posedge clk) begin
    if (bus.we && ram_sel) ram_mem[bus.RAMaddr[AW-1:0]] <= bus.RAMin;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push_req, push_ok, pop, full, stat_wr;
  tx_state_t     state_q;

  assign full     = (count_q == FIFO_FULL);
  assign pop      = (state_q == S_IDLE) && (count_q != 4'd0);
  assign push_req = bus.we && (bus.RAMaddr == A_TXDATA);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign stat_wr  = bus.we && (bus.RAMaddr == A_STATUS);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (stat_wr) ovf_d = 1'b0;
    if (push_req && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= bus.RAMin[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------- TX FSM ----------------
  logic [TW-1:0] timer_q;
  logic [7:0]    shift_q;
  logic [2:0]    idx_q;
  logic          tx_q;
  logic          busy;

  assign busy = (state_q != S_IDLE);
  assign tx   = tx_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      timer_q <= '0;
      shift_q <= 8'h00;
      idx_q   <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_mem[rd_ptr_q];
            timer_q <= BIT_RELOAD;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (timer_q == '0) begin
            tx_q    <= shift_q[0];
            idx_q   <= 3'd0;
            timer_q <= BIT_RELOAD;
            state_q <= S_DATA;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_DATA: begin
          if (timer_q == '0) begin
            timer_q <= BIT_RELOAD;
            if (idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              // bit 0 of the shift register is always the bit on the wire
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
              idx_q   <= idx_q + 3'd1;
            end
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        S_STOP: begin
          if (timer_q == '0) state_q <= S_IDLE;
          else               timer_q <= timer_q - TW'(1);
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- RX (optional) ----------------
  logic rxv;

`ifdef MEMIO_RX_EN
  localparam logic [15:0]   A_RXDATA    = 16'hFF02;
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     rx_state_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [TW-1:0] rx_timer_q;
  logic [2:0]    rx_idx_q;
  logic [7:0]    rx_shift_q;
  logic [7:0]    rx_data_q;
  logic          rxv_q;
  logic          rx_clr;

  assign rx_clr = bus.we && (bus.RAMaddr == A_RXDATA);
  assign rxv    = rxv_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= R_IDLE;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_timer_q <= '0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rxv_q      <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      if (rx_clr) rxv_q <= 1'b0;
      case (rx_state_q)
        R_IDLE: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_timer_q <= HALF_RELOAD;
            rx_state_q <= R_START;
          end
        end
        R_START: begin
          if (rx_timer_q == '0) begin
            if (!rx_s2_q) begin
              rx_timer_q <= BIT_RELOAD;
              rx_idx_q   <= 3'd0;
              rx_state_q <= R_DATA;
            end else begin
              rx_state_q <= R_IDLE;
            end
          end else begin
            rx_timer_q <= rx_timer_q - TW'(1);
          end
        end
        R_DATA: begin
          if (rx_timer_q == '0) begin
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_timer_q <= BIT_RELOAD;
            if (rx_idx_q == 3'd7) rx_state_q <= R_STOP;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end else begin
            rx_timer_q <= rx_timer_q - TW'(1);
          end
        end
        R_STOP: begin
          if (rx_timer_q == '0) begin
            // a new byte wins over a same-cycle clear
            if (rx_s2_q) begin
              rx_data_q <= rx_shift_q;
              rxv_q     <= 1'b1;
            end
            rx_state_q <= R_IDLE;
          end else begin
            rx_timer_q <= rx_timer_q - TW'(1);
          end
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end
`else
  assign rxv = 1'b0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    bus.RAMout = 16'h0000;
    if (ram_sel) begin
      bus.RAMout = ram_mem[bus.RAMaddr[AW-1:0]];
    end else if (bus.RAMaddr == A_STATUS) begin
      bus.RAMout = {8'h00, ovf_q, rxv, busy, full, count_q};
    end
`ifdef MEMIO_RX_EN
    else if (bus.RAMaddr == A_RXDATA) begin
      bus.RAMout = {8'h00, rx_data_q};
    end
`endif
  end

endmodule

// File: tb/tb_memio.sv
module tb_memio;
  localparam int CLK_DIV = 4;
  localparam logic [15:0] A_TXDATA = 16'hFF00;
  localparam logic [15:0] A_STATUS = 16'hFF01;
  localparam logic [15:0] A_RXDATA = 16'hFF02;

  typedef struct {
    int          kind;   // 0: RAMout, 1: tx
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  logic tx;
`ifdef MEMIO_RX_EN
  logic rx;
`endif

  memio_if bus ();

  memio #(.RAM_WORDS(1024), .FIFO_DEPTH(8), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx)
`ifdef MEMIO_RX_EN
    ,
    .rx    (rx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t m_e;
  logic [15:0] m_act;

  // Monitor: every expectation queued during a cycle is compared on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      m_e   = sb.pop_front();
      m_act = (m_e.kind == 0) ? bus.RAMout : {15'd0, tx};
      n_tests++;
      if (m_act !== m_e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h", m_e.name, m_act, m_e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ram(input string nm, input logic [15:0] v);
    exp_t e;
    e.kind = 0; e.exp = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic expect_tx(input string nm, input logic v);
    exp_t e;
    e.kind = 1; e.exp = {15'd0, v}; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.RAMaddr = a;
    bus.RAMin   = d;
    bus.we      = 1'b1;
    cyc();
    bus.we      = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input string nm, input logic [15:0] v);
    bus.RAMaddr = a;
    expect_ram(nm, v);
    cyc();
  endtask

  // Called right after the edge that enters START; walks the whole 10-bit frame.
  task automatic check_frame(input logic [7:0] b, input bit chk_stat, input logic [15:0] stat);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    bus.RAMaddr = A_STATUS;
    for (int i = 0; i < 10 * CLK_DIV; i++) begin
      expect_tx($sformatf("frame %02h bit %0d", b, i / CLK_DIV), f[i / CLK_DIV]);
      if (chk_stat) expect_ram($sformatf("frame %02h status", b), stat);
      cyc();
    end
  endtask

`ifdef MEMIO_RX_EN
  task automatic send_rx(input logic [7:0] b);
    rx = 1'b0;
    repeat (CLK_DIV) cyc();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) cyc();
    end
    rx = 1'b1;
    repeat (CLK_DIV) cyc();
  endtask
`endif

  initial begin
    bit found;
    reset       = 1'b0;
    bus.RAMaddr = 16'h0000;
    bus.RAMin   = 16'h0000;
    bus.we      = 1'b0;
`ifdef MEMIO_RX_EN
    rx = 1'b1;
`endif
    cyc();
    bus.RAMaddr = A_STATUS;
    expect_ram("reset status", 16'h0000);
    expect_tx("reset tx", 1'b1);
    cyc();
    reset = 1'b1;
    cyc();

    // RAM and unmapped addresses
    wr(16'h0010, 16'hBEEF);
    wr(16'h03FF, 16'h1234);
    rd(16'h0010, "ram 0x0010", 16'hBEEF);
    rd(16'h03FF, "ram 0x03FF", 16'h1234);
    rd(16'h0400, "unmapped 0x0400", 16'h0000);
    rd(A_TXDATA, "txdata read", 16'h0000);
    wr(16'hFF03, 16'h5555);
    rd(16'hFF03, "unmapped 0xFF03", 16'h0000);
`ifndef MEMIO_RX_EN
    wr(A_RXDATA, 16'h00AA);
    rd(A_RXDATA, "rxdata unmapped", 16'h0000);
`endif
    rd(A_STATUS, "status after unmapped writes", 16'h0000);

    // Single frame 0x41
    wr(A_TXDATA, 16'h0041);
    bus.RAMaddr = A_STATUS;
    expect_ram("status after push", 16'h0001);
    expect_tx("tx before start", 1'b1);
    cyc();
    check_frame(8'h41, 1'b1, 16'h0020);
    bus.RAMaddr = A_STATUS;
    expect_ram("status after frame", 16'h0000);
    expect_tx("tx after frame", 1'b1);
    cyc();

    // Overflow: 1 popped, 8 queued, 10th dropped
    for (int i = 1; i <= 10; i++) wr(A_TXDATA, 16'(i));
    rd(A_STATUS, "overflow status", 16'h00B8);
    wr(A_STATUS, 16'hFFFF);
    rd(A_STATUS, "status after ovf clear", 16'h0038);

    // Push into a full FIFO on the IDLE pop cycle
    bus.RAMaddr = A_STATUS;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cyc();
      if (bus.RAMout[5] == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle wait: busy still 1 after 200 cycles, expected 0");
    end
    expect_ram("full at idle pop cycle", 16'h0018);
    @(negedge clk);
    #1;
    bus.RAMaddr = A_TXDATA;
    bus.RAMin   = 16'h00AA;
    bus.we      = 1'b1;
    cyc();
    bus.we      = 1'b0;
    bus.RAMaddr = A_STATUS;
    expect_ram("push+pop while full", 16'h0038);
    check_frame(8'h02, 1'b0, 16'h0000);

    // Reset in the middle of byte 0x03, data bit 3 (low)
    cyc();
    repeat (16) cyc();
    expect_tx("pre-reset data bit", 1'b0);
    cyc();
    #1;
    reset = 1'b0;
    bus.RAMaddr = A_STATUS;
    expect_tx("tx forced high by reset", 1'b1);
    expect_ram("status in reset", 16'h0000);
    cyc();
    rd(16'h0010, "ram kept through reset", 16'hBEEF);
    reset = 1'b1;
    bus.RAMaddr = A_STATUS;
    repeat (6) cyc();
    expect_ram("status after reset release", 16'h0000);
    expect_tx("tx idle after reset", 1'b1);
    cyc();

`ifdef MEMIO_RX_EN
    send_rx(8'h5A);
    repeat (8) cyc();
    rd(A_STATUS, "rx status rxv", 16'h0040);
    rd(A_RXDATA, "rxdata", 16'h005A);
    wr(A_RXDATA, 16'h0000);
    rd(A_STATUS, "rxv cleared", 16'h0000);
    rx = 1'b0;
    cyc();
    rx = 1'b1;
    repeat (20) cyc();
    rd(A_STATUS, "glitch gives no byte", 16'h0000);
    rd(A_RXDATA, "rxdata after glitch", 16'h005A);
`endif

    repeat (3) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
